// File: rtl/adder_tree_accum_pkg.sv
// adder_tree_accum_pkg: shared state encoding and width helper for the frame accumulator.
package adder_tree_accum_pkg;
    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic int accum_out_width(input int in_w, input int len);
        return in_w + $clog2(len) + 1;
    endfunction
endpackage

// File: rtl/accum_out_fifo.sv
// accum_out_fifo: small synchronous FIFO with async reset; a push into a full FIFO succeeds when a pop happens in the same cycle.
module accum_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // When full, wr_ptr aliases rd_ptr: the slot being vacated by the pop is the one overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/adder_tree_accum.sv
// adder_tree_accum: sums ACC_LEN adder-tree beats per frame into a valid/ready FIFO, dropping frames when full.
// Define ADDER_TREE_ACCUM_MAX_EN to also report the largest beat of each frame on o_max.
module adder_tree_accum
    import adder_tree_accum_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int ACC_LEN    = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int OUT_WIDTH = accum_out_width(IN_WIDTH, ACC_LEN),
    localparam int CNT_W     = $clog2(ACC_LEN + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_sum,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [OUT_WIDTH-1:0] o_sum,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_overflow
`ifdef ADDER_TREE_ACCUM_MAX_EN
    ,output logic [IN_WIDTH-1:0] o_max
`endif
);
`ifdef ADDER_TREE_ACCUM_MAX_EN
    localparam int EW = OUT_WIDTH + CNT_W + IN_WIDTH;
    logic [IN_WIDTH-1:0] mx, mx_next, close_max;
`else
    localparam int EW = OUT_WIDTH + CNT_W;
`endif

    state_t state;
    logic [OUT_WIDTH-1:0] acc, acc_next, close_sum;
    logic [CNT_W-1:0] cnt, cnt_next, close_cnt;
    logic close, pop, full, empty;
    logic [EW-1:0] din, dout;

    // acc is zero while IDLE, so one adder serves both the first beat and later ones.
    assign acc_next  = acc + OUT_WIDTH'(i_sum);
    assign cnt_next  = cnt + CNT_W'(1);
    assign close     = (i_valid && cnt_next == CNT_W'(ACC_LEN)) || (i_flush && (state == ACCUM || i_valid));
    assign close_sum = i_valid ? acc_next : acc;
    assign close_cnt = i_valid ? cnt_next : cnt;
    assign pop       = o_valid && o_ready;
    assign o_valid   = !empty;

`ifdef ADDER_TREE_ACCUM_MAX_EN
    assign mx_next   = (state == IDLE || i_sum > mx) ? i_sum : mx;
    assign close_max = i_valid ? mx_next : mx;
    assign din       = {close_sum, close_cnt, close_max};
    assign {o_sum, o_count, o_max} = dout;
`else
    assign din       = {close_sum, close_cnt};
    assign {o_sum, o_count} = dout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            o_overflow <= 1'b0;
`ifdef ADDER_TREE_ACCUM_MAX_EN
            mx         <= '0;
`endif
        end else begin
            if (close) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
`ifdef ADDER_TREE_ACCUM_MAX_EN
                mx    <= '0;
`endif
            end else if (i_valid) begin
                state <= ACCUM;
                acc   <= acc_next;
                cnt   <= cnt_next;
`ifdef ADDER_TREE_ACCUM_MAX_EN
                mx    <= mx_next;
`endif
            end
            if (close && full && !pop) o_overflow <= 1'b1;
        end
    end

    accum_out_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (close),
        .pop   (pop),
        .din   (din),
        .full  (full),
        .empty (empty),
        .dout  (dout)
    );
endmodule

// File: tb/tb_adder_tree_accum.sv
// tb_adder_tree_accum: directed frames with a scoreboard queue checked by a negedge monitor on every handshake.
module tb_adder_tree_accum;
    logic        clk = 0;
    logic        rst;
    logic        i_valid, i_flush, o_ready;
    logic [7:0]  i_sum;
    logic        o_valid, o_overflow;
    logic [10:0] o_sum;
    logic [2:0]  o_count;
`ifdef ADDER_TREE_ACCUM_MAX_EN
    logic [7:0]  o_max;
`endif

    typedef struct {int s; int c; int m;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, pops = 0;

    adder_tree_accum dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sum(i_sum), .i_flush(i_flush),
        .o_valid(o_valid), .o_ready(o_ready), .o_sum(o_sum), .o_count(o_count),
        .o_overflow(o_overflow)
`ifdef ADDER_TREE_ACCUM_MAX_EN
        , .o_max(o_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got sum %0d count %0d expected none", o_sum, o_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_sum", int'(o_sum), e.s);
                chk("frame_count", int'(o_count), e.c);
`ifdef ADDER_TREE_ACCUM_MAX_EN
                chk("frame_max", int'(o_max), e.m);
`endif
                pops++;
            end
        end
    end

    task automatic expect_frame(input int s, input int c, input int m);
        exp_t e;
        e.s = s; e.c = c; e.m = m;
        q.push_back(e);
    endtask

    task automatic beat(input logic [7:0] v);
        i_valid = 1; i_sum = v;
        @(posedge clk); #1;
        i_valid = 0; i_sum = 0;
    endtask

    task automatic frame4(input logic [7:0] v);
        repeat (4) beat(v);
    endtask

    task automatic flush();
        i_flush = 1;
        @(posedge clk); #1;
        i_flush = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        o_ready = 1;
        while ((q.size() != 0 || o_valid) && k < 40) begin
            idle(1);
            k++;
        end
        if (k == 40) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int p0;
        rst = 1; i_valid = 0; i_flush = 0; i_sum = 0; o_ready = 0;
        #2;
        chk("reset_valid", o_valid, 0);
        chk("reset_sum", int'(o_sum), 0);
        chk("reset_count", int'(o_count), 0);
        chk("reset_overflow", o_overflow, 0);
        idle(2);
        rst = 0;
        idle(1);

        // Basic frame with one-cycle latency.
        o_ready = 1;
        expect_frame(100, 4, 40);
        beat(10); beat(20); beat(30); beat(40);
        chk("latency_valid", o_valid, 1);
        idle(1);
        chk("post_pop_valid", o_valid, 0);
        chk("empty_sum_zero", int'(o_sum), 0);

        // Full-scale beats must not truncate.
        expect_frame(1020, 4, 255);
        frame4(8'd255);
        drain();

        // Early flush, then a flush while idle that must push nothing.
        expect_frame(12, 2, 7);
        beat(5); beat(7);
        flush();
        drain();
        flush();
        idle(3);
        chk("idle_flush_no_frame", o_valid, 0);

        // Overflow: two frames queue, the third is dropped.
        o_ready = 0;
        expect_frame(4, 4, 1);
        expect_frame(4, 4, 1);
        frame4(8'd1); frame4(8'd1); frame4(8'd1);
        chk("overflow_set", o_overflow, 1);
        chk("full_hold_sum", int'(o_sum), 4);
        p0 = pops;
        drain();
        chk("drained_two", pops - p0, 2);
        chk("overflow_sticky", o_overflow, 1);

        // Reset mid-frame discards the partial frame and clears overflow.
        beat(3); beat(3);
        rst = 1;
        #1;
        chk("async_reset_overflow", o_overflow, 0);
        idle(1);
        rst = 0;
        expect_frame(12, 4, 3);
        frame4(8'd3);
        expect_frame(18, 4, 9);
        beat(3); beat(9); beat(2); beat(4);
        drain();

        // Close while full with a simultaneous pop: accepted, order kept.
        o_ready = 0;
        expect_frame(8, 4, 2);
        expect_frame(12, 4, 3);
        expect_frame(16, 4, 4);
        frame4(8'd2); frame4(8'd3);
        beat(4); beat(4); beat(4);
        o_ready = 1;
        beat(4);
        drain();
        chk("no_overflow_on_pop_push", o_overflow, 0);
        chk("scoreboard_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_tree_accum.md
Name: adder_tree_accum

Overview:
- Sits directly downstream of the adder tree. It consumes the tree's `sum_reg`/`o_valid` beats and accumulates ACC_LEN consecutive beats into one frame sum.
- Completed frame sums are presented on a valid/ready output through a small registered FIFO.
- The adder tree has no backpressure, so this block accepts a beat on every cycle. When the FIFO is full, the completed frame is dropped and flagged.

Parameters:
- IN_WIDTH, 8, width of the incoming tree sum (tree DATAWIDTH + $clog2(NUM_INPUTS-1)).
- ACC_LEN, 4, beats per frame; must be ≥ 2.
- FIFO_DEPTH, 2, output FIFO entries; must be ≥ 1.
- OUT_WIDTH (localparam), IN_WIDTH + $clog2(ACC_LEN) + 1, width of the frame sum.
- CNT_W (localparam), $clog2(ACC_LEN+1), width of the beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid; wired to the tree's o_valid.
- i_sum  in  IN_WIDTH  unsigned beat value; wired to the tree's sum_reg.
- i_flush  in  1  close the current frame early.
- o_valid  out  1  head of FIFO valid.
- o_ready  in  1  downstream accepts the head entry.
- o_sum  out  OUT_WIDTH  frame sum at the FIFO head.
- o_count  out  CNT_W  number of beats in the head frame (1..ACC_LEN).
- o_overflow  out  1  sticky: at least one frame was dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately): acc=0, cnt=0, state=IDLE, FIFO empty, o_valid=0, o_sum=0, o_count=0, o_overflow=0. A frame in progress when reset asserts is discarded.
- State machine: IDLE (cnt==0) and ACCUM (0 < cnt < ACC_LEN).
  - IDLE + i_valid: acc ← zero-extended i_sum, cnt ← 1, go to ACCUM.
  - ACCUM + i_valid: acc ← acc + i_sum, cnt ← cnt + 1.
- Frame completion: a "close" occurs on any cycle where either:
  - i_valid=1 and cnt+1 == ACC_LEN, or
  - i_flush=1 and (cnt > 0 or i_valid=1).
- Closing value is computed combinationally as (i_valid ? acc_next : acc), where acc_next includes the current beat. The closing count includes the current beat.
- On a close: push {value, count} to the FIFO, set acc=0 and cnt=0, go to IDLE.
- i_flush with cnt==0 and i_valid==0 does nothing; no empty frame is pushed.
- Arithmetic: unsigned, no wrap. OUT_WIDTH guarantees ACC_LEN × (2^IN_WIDTH − 1) fits.
- FIFO behaviour:
  - Pop when o_valid && o_ready.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the frame is dropped, o_overflow ← 1, and the FIFO contents are unchanged.
  - o_overflow clears only on reset.
- Latency: a frame closed in cycle N is visible with o_valid=1 at cycle N+1 if the FIFO was empty.
- Output stability: o_sum/o_count hold stable while o_valid && !o_ready. o_sum/o_count are 0 when the FIFO is empty.
- Throughput: one frame per ACC_LEN cycles sustained. With FIFO_DEPTH=1, back-to-back pop and push in the same cycle is supported.

Optional Feature:
- Macro ADDER_TREE_ACCUM_MAX_EN.
- When defined:
  - Adds output port o_max [IN_WIDTH-1:0]: the largest i_sum seen within the head frame.
  - A per-frame running max is tracked and reset to the first beat on IDLE→ACCUM.
  - The max is stored in the FIFO alongside the sum.
  - o_max is 0 at reset and when the FIFO is empty.
- When undefined: no port, no storage; all other behaviour is identical.

Decomposition:
- Package adder_tree_accum_pkg holds:
  - the state enum {IDLE, ACCUM};
  - function accum_out_width(in_w, len) returning in_w + $clog2(len) + 1.
- One sub-module: accum_out_fifo, a parameterised WIDTH/DEPTH synchronous FIFO with the same async reset. It exposes push/pop/full/empty, registered head output, and same-cycle push-when-full-with-pop support.

Test Plan:
- Four consecutive beats 10, 20, 30, 40 with o_ready=1 → one cycle after the 4th beat, o_valid=1, o_sum=100, o_count=4, then o_valid=0.
- Beats 255, 255, 255, 255 → o_sum=1020, with no truncation at OUT_WIDTH=11.
- Beats 5, 7, then i_flush=1 with i_valid=0 → o_sum=12, o_count=2. A flush while idle produces no output.
- o_ready=0, three full frames of beats all 1 → the first two are queued (sum 4 each); the third is dropped and o_overflow=1. Raising o_ready then drains exactly two entries, and o_overflow stays 1.
- FIFO full with o_ready=1 in the same cycle a frame closes → push is accepted, no overflow, and order is preserved.
- Reset asserted mid-frame after 2 beats, released, then 4 beats of 3 → o_sum=12, o_count=4. With ADDER_TREE_ACCUM_MAX_EN defined, beats 3, 9, 2, 4 give o_max=9.
